swipt_link_sequencer: RTL and testbench
=======================================

// Module: swipt_link_sequencer
// PURPOSE
//  Top-level controller for the SWIPT drive path; sits between heartbeat, SwiptOut, ADC_Comp and PLL2.
//  Once the heartbeat reports the link alive, it steps the drive frequency from F_MIN to F_MAX.
//  It measures comparator activity at each step; once the link is acquired it hands frequency
//  control to the PLL. It drops back to sweeping when the link is lost.
// PARAMETERS
//  F_MIN       32'h8CA0  sweep start frequency (Hz, 36 kHz)
//  F_MAX       32'hAFC8  sweep upper bound (Hz, 45 kHz)
//  F_STEP      32'h01F4  sweep increment (Hz, 500)
//  F_DEFAULT   32'h9C40  idle/reset frequency (Hz, 40 kHz)
//  SETTLE_CYC  1000      clk cycles waited after every frequency change
//  MEAS_CYC    256       measurement window length (clk cycles), >=2
//  LINK_THRESH 64        min adc_comp-high cycles per window for "link good"
//  MISS_LIMIT  3         consecutive bad windows in TRACK before declaring loss
//  RETRY_CYC   100000    FAULT back-off before re-sweep
// PORTS
//  clk         in   1   clock
//  nrst        in   1   reset, synchronous, active-high
//  swipt_alive in   1   heartbeat status (already synchronous to clk)
//  adc_comp    in   1   comparator output from ADC_Comp
//  pll_freq    in   32  PLL2 frequency estimate
//  freq_out    out  32  frequency word to SwiptOut
//  freq_load   out  1   1 = sequencer owns frequency (PLL2 freq_rdy); 0 = PLL tracking
//  drive_en    out  1   enable for SwiptOut bridge
//  state_out   out  3   current FSM state encoding
//  lock_lost   out  1   one-cycle pulse on TRACK -> SETTLE
//  sweep_fail  out  1   high while in FAULT
// BEHAVIOUR
//  Reset values: freq_out=F_DEFAULT, freq_load=1, drive_en=0, state=IDLE, lock_lost=0, sweep_fail=0.
//  All outputs registered. State is visible on state_out the cycle after the transition edge.
//  States: IDLE=0, SETTLE=1, MEASURE=2, TRACK=3, FAULT=4.
//  IDLE: drive_en=0, freq_out=F_DEFAULT. If swipt_alive=1, go to SETTLE with freq_out=F_MIN and drive_en=1.
//  SETTLE: count SETTLE_CYC cycles, then go to MEASURE. The hit counter is cleared on entry.
//  MEASURE: hit counter increments on every cycle with adc_comp=1, over MEAS_CYC cycles.
//   At window end:
//    - hits>=LINK_THRESH: go to TRACK; freq_load<=0.
//    - otherwise, if freq_out+F_STEP <= F_MAX: freq_out += F_STEP, go to SETTLE.
//    - otherwise: go to FAULT.
//   The sum is computed in 33 bits; carry-out counts as > F_MAX, so there is no wrap.
//  TRACK: freq_out = clamp(pll_freq, F_MIN, F_MAX), registered each cycle. Windows repeat back-to-back.
//   - A good window clears the miss counter.
//   - A bad window increments it.
//   - When it reaches MISS_LIMIT: lock_lost pulse, freq_load<=1, freq_out<=F_MIN, go to SETTLE.
//  FAULT: sweep_fail=1, drive_en=0; wait RETRY_CYC cycles, then go to SETTLE with freq_out=F_MIN and drive_en=1.
//  swipt_alive=0 in any non-IDLE state: go to IDLE next cycle and restore reset values of outputs.
//   This has priority over window end, MISS_LIMIT and timer expiry in the same cycle.
//   No lock_lost pulse is issued on this path.
//  nrst mid-operation: immediate return to reset values; all counters cleared.
//  Hit counter saturates at MEAS_CYC and is sized $clog2(MEAS_CYC+1).
// CONFIGURATION
//  SWIPT_SEQ_BEST_EN defined:
//   - MEASURE never exits early; the full F_MIN..F_MAX sweep runs.
//   - best_hits/best_freq are recorded. A strictly greater hit count replaces them; ties keep the lower frequency.
//   - After the last step: if best_hits>=LINK_THRESH, freq_out<=best_freq and go to SETTLE.
//     The extra settle+window then confirms TRACK. Otherwise go to FAULT.
//  Not defined: first-hit acquisition as above; no best_* registers are synthesised.
// STRUCTURE
//  Shared package swipt_pkg: state enum, F_DEFAULT/F_MIN/F_MAX/F_STEP defaults,
//   freq word width (32), duty width (12).
//  Sub-module link_window_counter (params MEAS_CYC, LINK_THRESH):
//   - inputs clk, nrst, start, adc_comp.
//   - outputs win_done (1-cycle pulse) and link_good (valid with win_done).
//   - used by MEASURE and TRACK.
// TESTING
//  1 Reset, swipt_alive=1, adc_comp=0 -> freq_out goes 0x8CA0, 0x8E94, ..., 0xAFC8 (19 steps),
//    then FAULT with sweep_fail=1 and drive_en=0.
//    After RETRY_CYC -> SETTLE with freq_out=0x8CA0.
//  2 adc_comp=1 only while freq_out==0x9C40 -> TRACK entered after that window; freq_load=0;
//    freq_out follows pll_freq=0x9D00. pll_freq=0x0 -> freq_out=0x8CA0 (clamp).
//  3 In TRACK, adc_comp=0 for 3 windows -> exactly one lock_lost pulse, freq_load=1, freq_out=0x8CA0.
//    2 bad windows then 1 good window -> no pulse.
//  4 swipt_alive drops in the same cycle as a window end with hits>=64 -> IDLE,
//    freq_out=0x9C40, drive_en=0, no TRACK entry.
//  5 nrst pulse mid-SETTLE -> all outputs at reset values the next cycle; the sweep restarts from 0x8CA0.
//  6 SWIPT_SEQ_BEST_EN: hits 70 at 0x9A4C and 90 at 0xA028 -> final freq_out=0xA028,
//    then TRACK after the confirm window.

Source files
------------

// File: rtl/swipt_link_sequencer_pkg.sv
// Shared types and defaults for the SWIPT link sequencer (package swipt_pkg).
package swipt_pkg;
  localparam int FREQ_W = 32;
  localparam int DUTY_W = 12;

  typedef logic [FREQ_W-1:0] freq_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_FAULT   = 3'd4
  } seq_state_t;

  localparam freq_t F_MIN_DEF     = 32'h0000_8CA0;
  localparam freq_t F_MAX_DEF     = 32'h0000_AFC8;
  localparam freq_t F_STEP_DEF    = 32'h0000_01F4;
  localparam freq_t F_DEFAULT_DEF = 32'h0000_9C40;

  // Limit a PLL estimate to the legal drive band.
  function automatic freq_t freq_clamp(input freq_t v, input freq_t lo, input freq_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/swipt_link_sequencer_if.sv
// Drive-path bundle between the sequencer and heartbeat/ADC_Comp/PLL2/SwiptOut.
// master: the sequencer; slave: the surrounding drive path.
interface swipt_link_sequencer_if;
  import swipt_pkg::*;

  logic       swipt_alive;
  logic       adc_comp;
  freq_t      pll_freq;
  freq_t      freq_out;
  logic       freq_load;
  logic       drive_en;
  logic [2:0] state_out;
  logic       lock_lost;
  logic       sweep_fail;

  modport master (
    input  swipt_alive, adc_comp, pll_freq,
    output freq_out, freq_load, drive_en, state_out, lock_lost, sweep_fail
  );

  modport slave (
    output swipt_alive, adc_comp, pll_freq,
    input  freq_out, freq_load, drive_en, state_out, lock_lost, sweep_fail
  );
endinterface

// File: rtl/swipt_link_sequencer_window.sv
// link_window_counter: counts adc_comp-high cycles over MEAS_CYC-cycle windows.
// start (level) holds the window cleared; once released, windows run back to back.
// win_done/link_good are combinational so the last sample of a window is included.
// SWIPT_SEQ_BEST_EN adds the win_hits output for best-frequency selection.
module link_window_counter #(
  parameter int unsigned MEAS_CYC    = 256,
  parameter int unsigned LINK_THRESH = 64,
  localparam int HW = $clog2(MEAS_CYC + 1),
  localparam int CW = $clog2(MEAS_CYC)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          adc_comp,
`ifdef SWIPT_SEQ_BEST_EN
  output logic [HW-1:0] win_hits,
`endif
  output logic          win_done,
  output logic          link_good
);
  logic [CW-1:0] cyc;
  logic [HW-1:0] hits, hits_nx;

  // Saturating hit count including the current sample.
  always_comb begin
    hits_nx = hits;
    if (adc_comp && hits != HW'(MEAS_CYC)) hits_nx = hits + HW'(1);
  end

  assign win_done  = !start && (cyc == CW'(MEAS_CYC - 1));
  assign link_good = 32'(hits_nx) >= LINK_THRESH;
`ifdef SWIPT_SEQ_BEST_EN
  assign win_hits  = hits_nx;
`endif

  // Window position and hit accumulation; restart after each window end.
  always_ff @(posedge clk) begin
    if (nrst || start || win_done) begin
      cyc  <= '0;
      hits <= '0;
    end else begin
      cyc  <= cyc + CW'(1);
      hits <= hits_nx;
    end
  end
endmodule

// File: rtl/swipt_link_sequencer.sv
// SWIPT link sequencer: sweeps the drive frequency until the comparator shows a link,
// hands control to the PLL while tracking, and re-sweeps on loss or after a fault back-off.
// Optional SWIPT_SEQ_BEST_EN: sweep the whole band, pick the best window, then confirm it.
module swipt_link_sequencer import swipt_pkg::*; #(
  parameter freq_t       F_MIN       = F_MIN_DEF,
  parameter freq_t       F_MAX       = F_MAX_DEF,
  parameter freq_t       F_STEP      = F_STEP_DEF,
  parameter freq_t       F_DEFAULT   = F_DEFAULT_DEF,
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned MEAS_CYC    = 256,
  parameter int unsigned LINK_THRESH = 64,
  parameter int unsigned MISS_LIMIT  = 3,
  parameter int unsigned RETRY_CYC   = 100000
) (
  input logic                    clk,
  input logic                    nrst,
  swipt_link_sequencer_if.master bus
);
  localparam int TW = $clog2(((SETTLE_CYC > RETRY_CYC) ? SETTLE_CYC : RETRY_CYC) + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  seq_state_t    state, state_n;
  freq_t         freq_q, freq_n;
  logic          load_q, load_n, drv_q, drv_n, lost_q, lost_n, fail_q, fail_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [MW-1:0] miss, miss_n;
  logic          win_done, link_good, win_start, step_ok;
  logic [FREQ_W:0] step_sum;

`ifdef SWIPT_SEQ_BEST_EN
  localparam int HW = $clog2(MEAS_CYC + 1);
  logic [HW-1:0] win_hits, best_hits, best_hits_n;
  freq_t         best_freq, best_freq_n;
  logic          confirm, confirm_n;
`endif

  // Window is held clear for the whole settle period, so MEASURE starts a fresh window.
  assign win_start = (state == ST_SETTLE);
  // 33-bit sum: a carry out can never look like an in-band frequency.
  assign step_sum  = {1'b0, freq_q} + {1'b0, F_STEP};
  assign step_ok   = step_sum <= {1'b0, F_MAX};

  link_window_counter #(.MEAS_CYC(MEAS_CYC), .LINK_THRESH(LINK_THRESH)) u_win (
    .clk       (clk),
    .nrst      (nrst),
    .start     (win_start),
    .adc_comp  (bus.adc_comp),
`ifdef SWIPT_SEQ_BEST_EN
    .win_hits  (win_hits),
`endif
    .win_done  (win_done),
    .link_good (link_good)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    freq_n  = freq_q;
    load_n  = load_q;
    drv_n   = drv_q;
    lost_n  = 1'b0;
    fail_n  = fail_q;
    miss_n  = miss;
`ifdef SWIPT_SEQ_BEST_EN
    best_hits_n = best_hits;
    best_freq_n = best_freq;
    confirm_n   = confirm;
`endif
    case (state)
      ST_IDLE: begin
        freq_n = F_DEFAULT;
        load_n = 1'b1;
        drv_n  = 1'b0;
        fail_n = 1'b0;
        miss_n = '0;
        if (bus.swipt_alive) begin
          state_n = ST_SETTLE;
          freq_n  = F_MIN;
          drv_n   = 1'b1;
        end
      end
      ST_SETTLE: if (tmr == TW'(SETTLE_CYC - 1)) state_n = ST_MEASURE;
      ST_MEASURE: if (win_done) begin
`ifdef SWIPT_SEQ_BEST_EN
        if (confirm) begin
          confirm_n = 1'b0;
          if (link_good) begin
            state_n = ST_TRACK; load_n = 1'b0; miss_n = '0;
          end else begin
            state_n = ST_FAULT; fail_n = 1'b1; drv_n = 1'b0;
          end
        end else begin
          // Strictly greater wins; the sweep ascends, so ties keep the lower frequency.
          if (win_hits > best_hits) begin
            best_hits_n = win_hits;
            best_freq_n = freq_q;
          end
          if (step_ok) begin
            freq_n = step_sum[FREQ_W-1:0]; state_n = ST_SETTLE;
          end else if (32'(best_hits_n) >= LINK_THRESH) begin
            freq_n = best_freq_n; confirm_n = 1'b1; state_n = ST_SETTLE;
          end else begin
            state_n = ST_FAULT; fail_n = 1'b1; drv_n = 1'b0;
          end
        end
`else
        if (link_good) begin
          state_n = ST_TRACK; load_n = 1'b0; miss_n = '0;
        end else if (step_ok) begin
          freq_n = step_sum[FREQ_W-1:0]; state_n = ST_SETTLE;
        end else begin
          state_n = ST_FAULT; fail_n = 1'b1; drv_n = 1'b0;
        end
`endif
      end
      ST_TRACK: begin
        freq_n = freq_clamp(bus.pll_freq, F_MIN, F_MAX);
        if (win_done) begin
          if (link_good) miss_n = '0;
          else if (32'(miss) + 32'd1 >= MISS_LIMIT) begin
            lost_n  = 1'b1;
            load_n  = 1'b1;
            freq_n  = F_MIN;
            miss_n  = '0;
            state_n = ST_SETTLE;
          end else miss_n = miss + MW'(1);
        end
      end
      ST_FAULT: if (tmr == TW'(RETRY_CYC - 1)) begin
        state_n = ST_SETTLE;
        freq_n  = F_MIN;
        drv_n   = 1'b1;
        fail_n  = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef SWIPT_SEQ_BEST_EN
    // Best-so-far only lives across one sweep.
    if (state == ST_IDLE || state == ST_TRACK || state == ST_FAULT) begin
      best_hits_n = '0;
      best_freq_n = F_MIN;
      confirm_n   = 1'b0;
    end
`endif
    // Heartbeat loss overrides every other event, with no lock_lost pulse.
    if (state != ST_IDLE && !bus.swipt_alive) begin
      state_n = ST_IDLE;
      freq_n  = F_DEFAULT;
      load_n  = 1'b1;
      drv_n   = 1'b0;
      lost_n  = 1'b0;
      fail_n  = 1'b0;
      miss_n  = '0;
`ifdef SWIPT_SEQ_BEST_EN
      best_hits_n = '0;
      best_freq_n = F_MIN;
      confirm_n   = 1'b0;
`endif
    end
    tmr_n = (state_n == state && (state == ST_SETTLE || state == ST_FAULT)) ? tmr + TW'(1) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state  <= ST_IDLE;
      freq_q <= F_DEFAULT;
      load_q <= 1'b1;
      drv_q  <= 1'b0;
      lost_q <= 1'b0;
      fail_q <= 1'b0;
      tmr    <= '0;
      miss   <= '0;
    end else begin
      state  <= state_n;
      freq_q <= freq_n;
      load_q <= load_n;
      drv_q  <= drv_n;
      lost_q <= lost_n;
      fail_q <= fail_n;
      tmr    <= tmr_n;
      miss   <= miss_n;
    end
  end

`ifdef SWIPT_SEQ_BEST_EN
  // Best-window bookkeeping.
  always_ff @(posedge clk) begin
    if (nrst) begin
      best_hits <= '0;
      best_freq <= F_MIN;
      confirm   <= 1'b0;
    end else begin
      best_hits <= best_hits_n;
      best_freq <= best_freq_n;
      confirm   <= confirm_n;
    end
  end
`endif

  assign bus.freq_out   = freq_q;
  assign bus.freq_load  = load_q;
  assign bus.drive_en   = drv_q;
  assign bus.state_out  = state;
  assign bus.lock_lost  = lost_q;
  assign bus.sweep_fail = fail_q;
endmodule

// File: tb/tb_swipt_link_sequencer.sv
// Bench for swipt_link_sequencer: directed sequences, a TRACK clamp vector table,
// and randomized stimulus, all shadowed by a cycle-level reference model.
module tb_swipt_link_sequencer;
  localparam int unsigned S  = 4;
  localparam int unsigned M  = 16;
  localparam int unsigned T  = 4;
  localparam int unsigned ML = 3;
  localparam int unsigned R  = 40;
  localparam longint FMIN = 32'h8CA0, FMAX = 32'hAFC8, FSTEP = 32'h01F4, FDEF = 32'h9C40;
`ifdef SWIPT_SEQ_BEST_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swipt_link_sequencer_if bus();

  swipt_link_sequencer #(.SETTLE_CYC(S), .MEAS_CYC(M), .LINK_THRESH(T),
                         .MISS_LIMIT(ML), .RETRY_CYC(R)) dut (
    .clk(clk), .nrst(rst), .bus(bus));

  int checks = 0, failures = 0;
  int adc_mode = 0;
  bit adc_const = 1'b0, rnd_bit = 1'b0;
  int win_pos = 0, prev_st = 0;

  function automatic int tgt(input logic [31:0] f);
    if (f == 32'h9A4C) return 5;
    if (f == 32'hA028) return 7;
    return 2;
  endfunction

  // Comparator stimulus: constant, tied to one frequency, random, or shaped per window.
  always_comb begin
    case (adc_mode)
      0:       bus.adc_comp = adc_const;
      1:       bus.adc_comp = (bus.freq_out == 32'h9C40);
      2:       bus.adc_comp = rnd_bit;
      default: bus.adc_comp = (bus.state_out == 3'd2) && (win_pos < tgt(bus.freq_out));
    endcase
  end

  // ---- reference model (countdown timers, plain int arithmetic) ----
  bit m_valid = 1'b0;
  int m_mode, m_left, m_wcnt, m_hits, m_miss, m_bh;
  longint m_freq, m_bf;
  bit m_load, m_drive, m_lost, m_fail, m_conf;

  task automatic model_reset();
    m_mode = 0; m_freq = FDEF; m_load = 1; m_drive = 0; m_lost = 0; m_fail = 0;
    m_left = 0; m_wcnt = 0; m_hits = 0; m_miss = 0; m_bh = 0; m_bf = FMIN; m_conf = 0;
  endtask

  task automatic go_settle(input longint f);
    m_mode = 1; m_left = S; m_freq = f;
  endtask

  task automatic go_fault();
    m_mode = 2'd0 + 4; m_left = R; m_fail = 1; m_drive = 0; m_bh = 0; m_conf = 0;
  endtask

  task automatic go_track();
    m_mode = 3; m_load = 0; m_miss = 0; m_bh = 0; m_conf = 0;
  endtask

  task automatic model_step();
    int h;
    bit good;
    if (rst) begin model_reset(); m_valid = 1; return; end
    m_lost = 0;
    if (m_mode != 0 && !bus.swipt_alive) begin model_reset(); return; end
    case (m_mode)
      0: if (bus.swipt_alive) begin go_settle(FMIN); m_drive = 1; end
      1: begin
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_wcnt = 0; m_hits = 0; end
      end
      2, 3: begin
        if (m_mode == 3) begin
          if (longint'(bus.pll_freq) < FMIN) m_freq = FMIN;
          else if (longint'(bus.pll_freq) > FMAX) m_freq = FMAX;
          else m_freq = bus.pll_freq;
        end
        m_wcnt++;
        m_hits += int'(bus.adc_comp);
        if (m_wcnt == M) begin
          h = m_hits; good = (h >= T); m_wcnt = 0; m_hits = 0;
          if (m_mode == 3) begin
            if (good) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss == ML) begin m_lost = 1; m_load = 1; m_miss = 0; go_settle(FMIN); end
            end
          end else if (!BEST) begin
            if (good) go_track();
            else if (m_freq + FSTEP <= FMAX) go_settle(m_freq + FSTEP);
            else go_fault();
          end else if (m_conf) begin
            if (good) go_track(); else go_fault();
          end else begin
            if (h > m_bh) begin m_bh = h; m_bf = m_freq; end
            if (m_freq + FSTEP <= FMAX) go_settle(m_freq + FSTEP);
            else if (m_bh >= T) begin m_conf = 1; go_settle(m_bf); end
            else go_fault();
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin go_settle(FMIN); m_drive = 1; m_fail = 0; end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [38:0] a, e;
    a = {bus.freq_out, bus.freq_load, bus.drive_en, bus.state_out, bus.lock_lost, bus.sweep_fail};
    e = {m_freq[31:0], m_load, m_drive, 3'(m_mode), m_lost, m_fail};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL model got=%h exp=%h @%0t", a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) compare_model();
    if (bus.state_out == 3'd2) win_pos = (prev_st == 2) ? win_pos + 1 : 0;
    prev_st = int'(bus.state_out);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (bus.state_out !== st && n < budget) begin tick(); n++; end
    checks++;
    if (bus.state_out !== st) begin
      failures++;
      $display("FAIL %s timeout state=%0d exp=%0d", name, bus.state_out, st);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  typedef struct { logic [31:0] pll; logic [31:0] exp; } vec_t;
  vec_t vecs[7];

  initial begin
    int steps, fc, pulses, tracks;
    logic [31:0] last, prev_settle, last_settle;
    bit found;
    vecs[0] = '{32'h9D00, 32'h9D00};  vecs[1] = '{32'h0000, 32'h8CA0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hAFC8}; vecs[3] = '{32'h8CA0, 32'h8CA0};
    vecs[4] = '{32'hAFC8, 32'hAFC8};  vecs[5] = '{32'h8C9F, 32'h8CA0};
    vecs[6] = '{32'hAFC9, 32'hAFC8};
    bus.swipt_alive = 1'b0; bus.pll_freq = 32'h9D00;

    // Reset values, then full sweep into FAULT and retry.
    do_reset();
    chk("rst_freq", bus.freq_out, 32'h9C40);   chk("rst_load", 32'(bus.freq_load), 1);
    chk("rst_drive", 32'(bus.drive_en), 0);    chk("rst_state", 32'(bus.state_out), 0);
    chk("rst_lost", 32'(bus.lock_lost), 0);    chk("rst_fail", 32'(bus.sweep_fail), 0);
    bus.swipt_alive = 1'b1; adc_mode = 0; adc_const = 1'b0;
    steps = 0; last = '0; fc = 0;
    while (bus.state_out !== 3'd4 && fc < 2000) begin
      tick(); fc++;
      if (bus.state_out == 3'd1 && bus.freq_out != last) begin
        chk("sweep_step", bus.freq_out, 32'(FMIN + steps * FSTEP));
        last = bus.freq_out; steps++;
      end
    end
    chk("sweep_count", steps, 19);
    chk("sweep_last", last, 32'hAFC8);
    chk("fault_fail", 32'(bus.sweep_fail), 1);
    chk("fault_drive", 32'(bus.drive_en), 0);
    fc = 0;
    while (bus.state_out == 3'd4 && fc < 200) begin fc++; tick(); end
    chk("fault_len", fc, R);
    chk("retry_state", 32'(bus.state_out), 1);
    chk("retry_freq", bus.freq_out, 32'h8CA0);
    chk("retry_drive", 32'(bus.drive_en), 1);
    chk("retry_fail", 32'(bus.sweep_fail), 0);

    // Acquisition at 0x9C40, then PLL clamp vectors.
    do_reset();
    bus.swipt_alive = 1'b1; adc_mode = 1; bus.pll_freq = 32'h9D00;
    wait_state(3'd3, 3000, "acq_track");
    chk("acq_freq", bus.freq_out, 32'h9C40);
    chk("acq_load", 32'(bus.freq_load), 0);
    adc_mode = 0; adc_const = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.pll_freq = vecs[i].pll;
      tick();
      chk("clamp_freq", bus.freq_out, vecs[i].exp);
      chk("clamp_state", 32'(bus.state_out), 3);
    end

    // Three bad windows: exactly one lock_lost pulse.
    adc_const = 1'b0; pulses = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (bus.lock_lost) begin
        pulses++;
        chk("loss_freq", bus.freq_out, 32'h8CA0);
        chk("loss_load", 32'(bus.freq_load), 1);
        chk("loss_state", 32'(bus.state_out), 1);
      end
    end
    chk("loss_pulses", pulses, 1);

    // Bad, bad, good: miss counter clears, no pulse.
    adc_const = 1'b1;
    wait_state(3'd3, 3000, "reacq_track");
    pulses = 0;
    for (int i = 0; i < 96; i++) begin
      adc_const = ((i % 48) >= 32);
      tick();
      if (bus.lock_lost) pulses++;
    end
    chk("miss_clear_pulses", pulses, 0);
    chk("miss_clear_state", 32'(bus.state_out), 3);

    // Heartbeat drop on the same cycle as a good window end.
    do_reset();
    bus.swipt_alive = 1'b1; adc_const = 1'b1;
    wait_state(3'd2, 100, "drop_measure");
    for (int i = 0; i < int'(M) - 1; i++) tick();
    bus.swipt_alive = 1'b0;
    tick();
    chk("drop_state", 32'(bus.state_out), 0);
    chk("drop_freq", bus.freq_out, 32'h9C40);
    chk("drop_drive", 32'(bus.drive_en), 0);
    chk("drop_lost", 32'(bus.lock_lost), 0);
    tracks = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.state_out == 3'd3) tracks++; end
    chk("drop_no_track", tracks, 0);

    // Reset in the middle of a later settle restarts the sweep.
    bus.swipt_alive = 1'b1; adc_const = 1'b0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (bus.state_out == 3'd1 && bus.freq_out == 32'h8E94);
    end
    chk("mid_settle_found", 32'(found), 1);
    tick();
    rst = 1'b1; tick();
    chk("mrst_freq", bus.freq_out, 32'h9C40); chk("mrst_state", 32'(bus.state_out), 0);
    chk("mrst_drive", 32'(bus.drive_en), 0);  chk("mrst_load", 32'(bus.freq_load), 1);
    rst = 1'b0; tick();
    chk("restart_state", 32'(bus.state_out), 1);
    chk("restart_freq", bus.freq_out, 32'h8CA0);

`ifdef SWIPT_SEQ_BEST_EN
    // Best-of-sweep: 5 hits at 0x9A4C, 7 at 0xA028; confirm at 0xA028.
    do_reset();
    bus.swipt_alive = 1'b1; adc_mode = 3; bus.pll_freq = 32'hA028;
    prev_settle = '0; last_settle = '0; fc = 0;
    while (bus.state_out !== 3'd3 && fc < 3000) begin
      tick(); fc++;
      if (bus.state_out == 3'd1 && bus.freq_out != last_settle) begin
        prev_settle = last_settle; last_settle = bus.freq_out;
      end
    end
    chk("best_track", 32'(bus.state_out), 3);
    chk("best_prev", prev_settle, 32'hAFC8);
    chk("best_freq", last_settle, 32'hA028);
    chk("best_load", 32'(bus.freq_load), 0);
`endif

    // Randomized traffic against the model.
    adc_mode = 2;
    for (int seg = 0; seg < 20; seg++) begin
      int prob;
      case ($urandom_range(4))
        0: prob = 0;  1: prob = 15; 2: prob = 30; 3: prob = 60; default: prob = 100;
      endcase
      for (int i = 0; i < 200; i++) begin
        bus.swipt_alive = ($urandom_range(299) != 0);
        rst = ($urandom_range(1499) == 0);
        bus.pll_freq = $urandom_range(1) ? 32'($urandom_range(32'hB400, 32'h8800)) : $urandom;
        rnd_bit = ($urandom_range(99) < prob);
        tick();
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
